// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencing FSM for the SISC datapath; define CTRL_MEM_STALL_EN to enable the mem_rdy handshake and stall timeout
module ctrl_seq #(
  parameter int OP_W        = 4,
  parameter int CC_W        = 4,
  parameter int AM_IMM      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OP_W-1:0] opcode,
  input  logic [CC_W-1:0] mm,
  input  logic [CC_W-1:0] stat,
  input  logic            mem_rdy,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            rd_sel,
  output logic            br_sel,
  output logic            pc_rst,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            ir_load,
  output logic            dm_we,
  output logic            mm_sel,
  output logic [1:0]      alu_op,
  output logic            instr_done,
  output logic            halted,
  output logic            mem_err
);
  typedef enum logic [2:0] {START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
  state_t r_state, w_next;
  logic w_lod, w_str, w_bra, w_brr, w_bne, w_bnr, w_alu, w_hlt, w_mem_op, w_hit, w_taken;
  logic w_rdy, w_timeout;
  assign w_lod    = opcode == OP_W'(1);
  assign w_str    = opcode == OP_W'(2);
  assign w_bra    = opcode == OP_W'(4);
  assign w_brr    = opcode == OP_W'(5);
  assign w_bne    = opcode == OP_W'(6);
  assign w_bnr    = opcode == OP_W'(7);
  assign w_alu    = opcode == OP_W'(8);
  assign w_hlt    = opcode == OP_W'(15);
  assign w_mem_op = w_lod | w_str;
  assign w_hit    = |(mm & stat);
  assign w_taken  = ((w_bra | w_brr) & w_hit) | ((w_bne | w_bnr) & ~w_hit);
`ifdef CTRL_MEM_STALL_EN
  localparam int CNT_W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = MEM_TIMEOUT > 0 ? CNT_W'(MEM_TIMEOUT) : {CNT_W{1'b1}};
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;
  assign w_rdy     = mem_rdy;
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_state == MEM) && (r_cnt == CNT_MAX) && !mem_rdy;
  assign mem_err   = r_mem_err;
  // stall counter: consecutive not-ready MEM cycles, held at zero outside MEM, saturating
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) r_cnt <= '0;
    else r_cnt <= (r_state != MEM) ? '0 : (!mem_rdy && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
  // sticky memory timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) r_mem_err <= 1'b0;
    else r_mem_err <= r_mem_err | w_timeout;
`else
  assign w_rdy     = mem_rdy | 1'b1;
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif
  // state register; reset parks the FSM in START1 so the PC is cleared before the first fetch
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) r_state <= START1;
    else r_state <= w_next;
  // next-state and datapath controls
  always_comb begin
    w_next     = r_state;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    rd_sel     = 1'b0;
    br_sel     = 1'b0;
    pc_rst     = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    ir_load    = 1'b0;
    dm_we      = 1'b0;
    mm_sel     = 1'b0;
    alu_op     = 2'b10;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (r_state)
      START0:  w_next = START1;
      START1: begin
        pc_rst = 1'b1;
        w_next = FETCH;
      end
      FETCH: begin
        pc_write = 1'b1;
        ir_load  = 1'b1;
        mm_sel   = 1'b1;
        w_next   = DECODE;
      end
      DECODE: begin
        br_sel     = w_bra | w_bne;
        pc_write   = w_taken;
        pc_sel     = w_taken;
        instr_done = ~(w_hlt | w_alu | w_mem_op);
        w_next     = w_hlt ? HALT : (w_alu | w_mem_op) ? EXECUTE : FETCH;
      end
      EXECUTE: begin
        alu_op = w_alu ? 2'b01 : w_mem_op ? 2'b11 : 2'b10;
        w_next = w_mem_op ? MEM : w_alu ? WB : FETCH;
      end
      MEM: begin
        alu_op     = 2'b11;
        rd_sel     = 1'b1;
        mm_sel     = mm != CC_W'(AM_IMM);
        dm_we      = w_str;
        instr_done = w_str & w_rdy;
        w_next     = w_timeout ? HALT : !w_rdy ? MEM : w_lod ? WB : FETCH;
      end
      WB: begin
        rf_we      = 1'b1;
        wb_sel     = w_alu;
        alu_op     = w_alu ? 2'b01 : 2'b10;
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      HALT:    halted = 1'b1;
      default: w_next = START1;
    endcase
  end
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed-vector bench for ctrl_seq, covers the stall/timeout paths when CTRL_MEM_STALL_EN is defined
module tb_ctrl_seq;
  localparam logic [14:0] RF = 15'h4000, WBS = 15'h2000, RD = 15'h1000, BR = 15'h0800;
  localparam logic [14:0] PR = 15'h0400, PW = 15'h0200, PS = 15'h0100, IR = 15'h0080;
  localparam logic [14:0] DW = 15'h0040, MS = 15'h0020, A01 = 15'h0008, A10 = 15'h0010;
  localparam logic [14:0] A11 = 15'h0018, ID = 15'h0004, HL = 15'h0002, ME = 15'h0001;
  localparam logic [14:0] S_RST = PR | A10, S_FETCH = PW | IR | MS | A10;
  logic clk = 1'b0;
  logic rst_f;
  logic [3:0] opcode, mm, stat;
  logic mem_rdy;
  logic rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, mm_sel;
  logic [1:0] alu_op;
  logic instr_done, halted, mem_err;
  logic [14:0] outs;
  int n_chk = 0;
  int n_err = 0;
  ctrl_seq #(.OP_W(4), .CC_W(4), .AM_IMM(8), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
    .rf_we(rf_we), .wb_sel(wb_sel), .rd_sel(rd_sel), .br_sel(br_sel), .pc_rst(pc_rst),
    .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load), .dm_we(dm_we), .mm_sel(mm_sel),
    .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .mem_err(mem_err)
  );
  assign outs = {rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, mm_sel,
                 alu_op, instr_done, halted, mem_err};
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [14:0] exp);
    n_chk++;
    assert (outs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, outs, exp);
    end
  endtask
  task automatic go(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
    opcode = op;
    mm     = m;
    stat   = s;
  endtask
  initial begin
    rst_f = 1'b0;
    go(4'd0, 4'd0, 4'd0);
    mem_rdy = 1'b0;
    step;
    chk("reset", S_RST);
    rst_f = 1'b1;
    chk("start1_after_release", S_RST);
    step;
    // ALU: FETCH, DECODE, EXECUTE, WB, FETCH
    go(4'd8, 4'd0, 4'd0);
    chk("alu_fetch", S_FETCH);
    step; chk("alu_decode", A10);
    step; chk("alu_execute", A01);
    step; chk("alu_wb", RF | WBS | A01 | ID);
    step; chk("alu_next_fetch", S_FETCH);
    // BRA taken
    go(4'd4, 4'b0010, 4'b0010);
    step; chk("bra_taken_decode", BR | PW | PS | A10 | ID);
    step; chk("bra_next_fetch", S_FETCH);
    // BNR not taken with the same flags
    go(4'd7, 4'b0010, 4'b0010);
    step; chk("bnr_not_taken_decode", A10 | ID);
    step; chk("bnr_next_fetch", S_FETCH);
    // BRR not taken, BNE taken
    go(4'd5, 4'b0010, 4'b0100);
    step; chk("brr_not_taken_decode", A10 | ID);
    step; chk("brr_next_fetch", S_FETCH);
    go(4'd6, 4'b0010, 4'b0100);
    step; chk("bne_taken_decode", BR | PW | PS | A10 | ID);
    step; chk("bne_next_fetch", S_FETCH);
    // unknown opcode behaves as NOOP
    go(4'd3, 4'd0, 4'd0);
    step; chk("unknown_decode", A10 | ID);
    step; chk("unknown_next_fetch", S_FETCH);
    // STR with immediate addressing
    go(4'd2, 4'd8, 4'd0);
    mem_rdy = 1'b0;
    step; chk("str_decode", A10);
    step; chk("str_execute", A11);
`ifdef CTRL_MEM_STALL_EN
    for (int i = 0; i < 3; i++) begin
      step; chk("str_mem_stall", RD | A11 | DW);
    end
    mem_rdy = 1'b1;
    step; chk("str_mem_ready", RD | A11 | DW | ID);
`else
    step; chk("str_mem_ready_ignored", RD | A11 | DW | ID);
`endif
    step; chk("str_next_fetch", S_FETCH);
    // LOD register addressing, memory ready at once
    go(4'd1, 4'd0, 4'd0);
    mem_rdy = 1'b1;
    step; chk("lod_decode", A10);
    step; chk("lod_execute", A11);
    step; chk("lod_mem", RD | A11 | MS);
    step; chk("lod_wb", RF | A10 | ID);
    step; chk("lod_next_fetch", S_FETCH);
`ifdef CTRL_MEM_STALL_EN
    // LOD completing on the last cycle before timeout
    mem_rdy = 1'b0;
    step; chk("lod_edge_decode", A10);
    step; chk("lod_edge_execute", A11);
    for (int i = 0; i < 15; i++) begin
      step; chk("lod_edge_stall", RD | A11 | MS);
    end
    mem_rdy = 1'b1;
    step; chk("lod_edge_mem_ready", RD | A11 | MS);
    step; chk("lod_edge_wb", RF | A10 | ID);
    step; chk("lod_edge_next_fetch", S_FETCH);
    // LOD timeout: 16 MEM cycles then HALT with mem_err
    mem_rdy = 1'b0;
    step; chk("lod_to_decode", A10);
    step; chk("lod_to_execute", A11);
    for (int i = 0; i < 16; i++) begin
      step; chk("lod_to_stall", RD | A11 | MS);
    end
    step; chk("lod_timeout_halt", HL | A10 | ME);
    step; chk("lod_timeout_halt_hold", HL | A10 | ME);
    rst_f = 1'b0;
    #1; chk("reset_clears_err", S_RST);
    step;
    rst_f = 1'b1;
    step; chk("after_err_fetch", S_FETCH);
    // async reset during a MEM stall
    go(4'd2, 4'd0, 4'd0);
    step; chk("str_stall_decode", A10);
    step; chk("str_stall_execute", A11);
    step; chk("str_stall_mem", RD | A11 | DW | MS);
    step; chk("str_stall_mem2", RD | A11 | DW | MS);
    rst_f = 1'b0;
    #1; chk("reset_mid_mem", S_RST);
    step;
    rst_f = 1'b1;
    step; chk("after_mem_reset_fetch", S_FETCH);
`endif
    // async reset during EXECUTE
    go(4'd8, 4'd0, 4'd0);
    step; chk("rst_exec_decode", A10);
    step; chk("rst_exec_execute", A01);
    rst_f = 1'b0;
    #1; chk("reset_mid_execute", S_RST);
    step; chk("reset_held", S_RST);
    rst_f = 1'b1;
    chk("reset_released_start1", S_RST);
    step; chk("after_exec_reset_fetch", S_FETCH);
    // HLT parks the FSM
    go(4'd15, 4'd0, 4'd0);
    step; chk("hlt_decode", A10);
    for (int i = 0; i < 20; i++) begin
      step; chk("halt_hold", HL | A10);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised successor to the SISC control FSM. Sequences each instruction through only the states it needs: branches and NOOP retire after decode, ALU ops skip memory, and stores skip writeback. Adds a data-memory ready handshake with a bounded stall timeout, a real halt state, and per-instruction retire and status outputs. Sits between the instruction register/status register and the datapath (PC, register file, ALU, data memory muxes).

## Interface
- OP_W, 4, opcode width; opcode values below are zero-extended to OP_W
- CC_W, 4, width of `mm` (condition mask / addressing mode) and `stat`
- AM_IMM, 8, `mm` value selecting immediate addressing for LOD/STR
- MEM_TIMEOUT, 15, maximum consecutive stalled MEM cycles; 0 disables the timeout

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_f  in  1  asynchronous, active-low reset
- opcode  in  OP_W  current instruction opcode from IR
- mm  in  CC_W  condition mask / addressing mode field from IR
- stat  in  CC_W  status flags
- mem_rdy  in  1  data memory completed the access this cycle
- rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, mm_sel  out  1 each  datapath controls
- alu_op  out  2  ALU function select
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- halted  out  1  FSM is in HALT
- mem_err  out  1  sticky: memory timeout occurred

## Operation
- Opcodes: NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15. Any other value is executed as NOOP.
- States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, HALT (3-bit encoding).
- Transitions:
  - START0→START1; START1→FETCH; FETCH→DECODE.
  - DECODE: HLT→HALT; ALU/LOD/STR→EXECUTE; all others→FETCH.
  - EXECUTE: LOD/STR→MEM; ALU→WB.
  - MEM: stays while `mem_rdy`=0. When `mem_rdy`=1: LOD→WB, STR→FETCH.
  - MEM timeout: when the stall counter reaches MEM_TIMEOUT with `mem_rdy` still 0, go to HALT and set `mem_err`.
  - WB→FETCH; HALT→HALT until reset.
- Outputs are combinational from state, opcode, mm, stat. Defaults are all 0 with `alu_op`=2'b10.
  - START1: `pc_rst`=1.
  - FETCH: `pc_write`, `ir_load`, `mm_sel` = 1.
  - DECODE:
    - `br_sel`=1 for BRA/BNE, 0 for BRR/BNR.
    - Branch is taken when BRA/BRR and (mm & stat)≠0, or when BNE/BNR and (mm & stat)=0.
    - Taken branch drives `pc_write`=1 and `pc_sel`=1.
  - EXECUTE: ALU drives `alu_op`=01; LOD/STR drive `alu_op`=11.
  - MEM (LOD/STR):
    - `alu_op`=11, `rd_sel`=1.
    - `mm_sel`=0 if mm==AM_IMM, else 1.
    - STR holds `dm_we`=1 for every MEM cycle.
  - WB: `rf_we`=1. ALU drives `wb_sel`=1 and `alu_op`=01; LOD drives `wb_sel`=0.
  - `instr_done`=1 in DECODE for NOOP/branch/unknown, in MEM on the `mem_rdy` cycle for STR, and in WB for ALU/LOD.
  - `halted`=1 in HALT.
- Stall counter: width $clog2(MEM_TIMEOUT+1). Cleared on MEM entry; increments each MEM cycle with `mem_rdy`=0; saturates.

## Timing
- Reset (`rst_f` low, asynchronous, any state including mid-MEM stall):
  - State becomes START1, counter clears, `mem_err` clears.
  - While in reset, outputs are `pc_rst`=1, `alu_op`=10, all others 0.
- START0 is the simulation power-up state only.
- Latency from FETCH to next FETCH, with no stall:
  - NOOP or branch: 2 cycles.
  - ALU: 4 cycles.
  - STR: 4 cycles.
  - LOD: 5 cycles.
  - Each MEM cycle with `mem_rdy`=0 adds one cycle.
- `mem_rdy` is sampled only in MEM and ignored in every other state. If `mem_rdy`=1 on the first MEM cycle, there is no stall.
- Timeout boundary: with MEM_TIMEOUT=N, there are exactly N stalled MEM cycles. If the next cycle still has `mem_rdy`=0, the FSM goes to HALT. If `mem_rdy`=1 arrives in that cycle, the access completes normally.
- `dm_we` never asserts outside MEM. `rf_we` never asserts outside WB.

## Configuration
- CTRL_MEM_STALL_EN:
  - When defined: `mem_rdy` handshake and timeout behave as above.
  - When undefined:
    - MEM always lasts one cycle and `mem_rdy` is ignored.
    - Stall counter is not built; `mem_err` is tied to 0.
    - MEM_TIMEOUT has no effect.

## Test plan
- Reset then ALU (opcode=8, mm=0): START1→FETCH→DECODE→EXECUTE→WB. `rf_we`=1, `wb_sel`=1 in WB only; `instr_done` pulses once.
- BRA mm=4'b0010, stat=4'b0010 → DECODE has `pc_write`=1, `pc_sel`=1, `br_sel`=1. BNR with the same values → `pc_write`=0 in DECODE; next state is FETCH.
- STR mm=8 with `mem_rdy` low for 3 cycles, then high → `dm_we`=1 for 4 MEM cycles and `mm_sel`=0; no WB; next FETCH at cycle 8.
- LOD with `mem_rdy` never high, MEM_TIMEOUT=15 → HALT after 16 MEM cycles; `mem_err`=1 and `halted`=1. Then `rst_f` low → `pc_rst`=1 and `mem_err`=0.
- HLT (opcode=15) → FETCH, DECODE, then HALT persists 20 cycles; `halted`=1, no `pc_write`.
- Assert `rst_f` low asynchronously mid-EXECUTE and mid-MEM stall → state is START1 immediately, and the first FETCH follows reset release.
